// File: rtl/rs_alloc_tracker_pkg.sv
// Shared constants for reservation-station allocation: RS type codes, per-type entry counts,
// and the index-width helper used to size the trackers.
package rs_alloc_tracker_pkg;

    typedef enum logic [1:0] {
        RsAlu,
        RsBranch,
        RsMul,
        RsLdst
    } rs_type_e;

    localparam int unsigned ALU_ENT_NUM    = 8;
    localparam int unsigned BRANCH_ENT_NUM = 4;
    localparam int unsigned MUL_ENT_NUM    = 2;
    localparam int unsigned LDST_ENT_NUM   = 4;

    function automatic int unsigned ent_sel_of(input int unsigned ent_num);
        return $clog2(ent_num);
    endfunction

endpackage

// File: rtl/rs_free_pe.sv
// Lowest-index priority encoder over a free-entry mask; valid is low when no entry is free.
module rs_free_pe
    import rs_alloc_tracker_pkg::*;
#(
    parameter int unsigned ENT_NUM = ALU_ENT_NUM,
    parameter int unsigned ENT_SEL = ent_sel_of(ENT_NUM)
) (
    input  logic [ENT_NUM-1:0] free_mask,
    output logic [ENT_SEL-1:0] idx,
    output logic               valid
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx   = ENT_SEL'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alloc_tracker.sv
// Reservation-station entry allocator: hands out up to two free entries per cycle and frees
// entries on issue or flush.
module rs_alloc_tracker
    import rs_alloc_tracker_pkg::*;
#(
    parameter int unsigned ENT_NUM = ALU_ENT_NUM,
    parameter int unsigned ENT_SEL = ent_sel_of(ENT_NUM)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req1_i,
    input  logic               req2_i,
    input  logic [1:0]         reqnum_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               issue_valid_i,
    input  logic [ENT_SEL-1:0] issue_addr_i,
    output logic               allocatable_o,
    output logic [ENT_SEL-1:0] alloc_ent1_o,
    output logic [ENT_SEL-1:0] alloc_ent2_o,
    output logic [ENT_SEL:0]   free_cnt_o,
    output logic [ENT_NUM-1:0] busy_vec_o
);

    localparam int unsigned CW = ENT_SEL + 1;

    logic [ENT_NUM-1:0] busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ENT_SEL-1:0] fe1, fe2;
    logic               fe1_valid, fe2_valid;
    logic [ENT_NUM-1:0] free_mask, free_mask2;
    logic               commit, release_ok;
    logic [CW-1:0]      n_alloc, n_rel;

    assign free_mask  = ~busy_q;
    assign free_mask2 = free_mask & ~(ENT_NUM'(1) << fe1);

    rs_free_pe #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL)) u_pe1 (
        .free_mask (free_mask),
        .idx       (fe1),
        .valid     (fe1_valid)
    );

    rs_free_pe #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL)) u_pe2 (
        .free_mask (free_mask2),
        .idx       (fe2),
        .valid     (fe2_valid)
    );

    assign alloc_ent1_o  = fe1;
    assign alloc_ent2_o  = req1_i ? fe2 : fe1;
    assign allocatable_o = (cnt_q >= CW'(reqnum_i));

    assign commit     = allocatable_o && !stall_i && !flush_i;
    // Issuing an idle entry is a protocol error; ignoring it keeps the count consistent.
    assign release_ok = issue_valid_i && !flush_i && busy_q[issue_addr_i];
    assign n_alloc    = commit ? (CW'(req1_i) + CW'(req2_i)) : '0;
    assign n_rel      = CW'(release_ok);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q - n_alloc + n_rel;
        if (commit && req1_i) busy_d[alloc_ent1_o] = 1'b1;
        if (commit && req2_i) busy_d[alloc_ent2_o] = 1'b1;
        if (release_ok)       busy_d[issue_addr_i] = 1'b0;
        if (flush_i) begin
            busy_d = '0;
            cnt_d  = CW'(ENT_NUM);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
            cnt_q  <= CW'(ENT_NUM);
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign free_cnt_o = cnt_q;
    assign busy_vec_o = busy_q;

    a_issue_busy: assert property (@(posedge clk_i) disable iff (reset_i)
        (issue_valid_i && !flush_i) |-> busy_q[issue_addr_i]);

    a_reqnum: assert property (@(posedge clk_i) disable iff (reset_i)
        reqnum_i == ({1'b0, req1_i} + {1'b0, req2_i}));

    a_count: assert property (@(posedge clk_i) disable iff (reset_i)
        (int'(cnt_q) + $countones(busy_q)) == int'(ENT_NUM));

    a_fe_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        commit |-> ((!req1_i && !req2_i) || fe1_valid) && (!(req1_i && req2_i) || fe2_valid));

endmodule

// File: tb/tb_rs_alloc_tracker.sv
// Randomized bench for rs_alloc_tracker against an entry-array reference model.
module tb_rs_alloc_tracker;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       req1_i = 1'b0, req2_i = 1'b0;
    logic [1:0] reqnum_i = 2'd0;
    logic       stall_i = 1'b0, flush_i = 1'b0;
    logic       issue_valid_i = 1'b0;
    logic [2:0] issue_addr_i = 3'd0;
    logic       allocatable_o;
    logic [2:0] alloc_ent1_o, alloc_ent2_o;
    logic [3:0] free_cnt_o;
    logic [7:0] busy_vec_o;

    int n_checks = 0;
    int n_errors = 0;
    bit m_busy[N];

    rs_alloc_tracker #(.ENT_NUM(8), .ENT_SEL(3)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req1_i        (req1_i),
        .req2_i        (req2_i),
        .reqnum_i      (reqnum_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .issue_valid_i (issue_valid_i),
        .issue_addr_i  (issue_addr_i),
        .allocatable_o (allocatable_o),
        .alloc_ent1_o  (alloc_ent1_o),
        .alloc_ent2_o  (alloc_ent2_o),
        .free_cnt_o    (free_cnt_o),
        .busy_vec_o    (busy_vec_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (!m_busy[i]) c++;
        return c;
    endfunction

    function automatic int m_lowest_free(input int skip);
        for (int i = 0; i < N; i++) if (!m_busy[i] && i != skip) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_vec();
        logic [7:0] v;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // One cycle: drive, check combinational outputs, clock, update model, check state.
    task automatic step(input bit r1, input bit r2, input bit st, input bit fl,
                        input bit iv, input int ia, input bit rst);
        int  need, e1, e2;
        bit  ok, was_busy;
        req1_i = r1; req2_i = r2; reqnum_i = 2'(int'(r1) + int'(r2));
        stall_i = st; flush_i = fl; issue_valid_i = iv; issue_addr_i = 3'(ia);
        reset_i = rst;
        #2;
        need = int'(r1) + int'(r2);
        ok   = m_free_count() >= need;
        e1   = m_lowest_free(-1);
        e2   = r1 ? m_lowest_free(e1) : e1;
        check("allocatable", 32'(allocatable_o), 32'(ok));
        if (ok && need > 0) begin
            if (r1) check("alloc_ent1", 32'(alloc_ent1_o), 32'(e1));
            if (r2) check("alloc_ent2", 32'(alloc_ent2_o), 32'(e2));
        end
        @(posedge clk);
        #1;
        if (rst || fl) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        end else begin
            was_busy = m_busy[ia];
            if (ok && !st) begin
                if (r1) m_busy[e1] = 1'b1;
                if (r2) m_busy[e2] = 1'b1;
            end
            if (iv && was_busy) m_busy[ia] = 1'b0;
        end
        check("busy_vec", 32'(busy_vec_o), 32'(m_vec()));
        check("free_cnt", 32'(free_cnt_o), 32'(m_free_count()));
    endtask

    initial begin
        int ia;
        bit iv;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        req1_i = 1'b1; req2_i = 1'b0; reqnum_i = 2'd1;
        #1;
        check("reset_busy", 32'(busy_vec_o), 32'h0);
        check("reset_cnt", 32'(free_cnt_o), 32'd8);
        check("reset_ent1", 32'(alloc_ent1_o), 32'd0);
        check("reset_ent2", 32'(alloc_ent2_o), 32'd1);

        step(1, 1, 0, 0, 0, 0, 0);
        check("dir_pair_busy", 32'(busy_vec_o), 32'h03);
        step(0, 1, 0, 0, 0, 0, 0);
        check("dir_solo2_busy", 32'(busy_vec_o), 32'h07);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("dir_7f_busy", 32'(busy_vec_o), 32'h7F);
        step(1, 1, 0, 0, 0, 0, 0);
        check("dir_nopartial", 32'(busy_vec_o), 32'h7F);
        step(1, 0, 0, 0, 0, 0, 0);
        check("dir_full_cnt", 32'(free_cnt_o), 32'd0);
        step(1, 0, 0, 0, 1, 3, 0);
        check("dir_issue3", 32'(busy_vec_o), 32'hF7);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 5, 0);
        check("dir_flush", 32'(busy_vec_o), 32'h00);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0);
        check("dir_alloc_rel", 32'(busy_vec_o), 32'h3E);
        check("dir_alloc_rel_cnt", 32'(free_cnt_o), 32'd3);
        step(1, 1, 1, 0, 0, 0, 0);
        check("dir_stall", 32'(busy_vec_o), 32'h3E);
        step(1, 1, 0, 0, 1, 1, 1);
        check("dir_reset", 32'(free_cnt_o), 32'd8);

        for (int n = 0; n < 3000; n++) begin
            iv = 1'b0;
            ia = $urandom_range(0, N - 1);
            if (m_free_count() < N && $urandom_range(0, 1) == 1) begin
                while (!m_busy[ia]) ia = (ia + 1) % N;
                iv = 1'b1;
            end
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0,
                 iv, ia, $urandom_range(0, 250) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
